// File: rtl/wisc_pkg.sv
// Shared write-back definitions: register-file geometry and the queued entry format.
package wisc_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  localparam logic [REG_W-1:0] R0_IDX = '0;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_queue_if.sv
// Producer, register-file write port and operand-lookup signals of the write-back queue.
interface writeback_queue_if
  import wisc_pkg::*;
#(
  parameter int DEPTH = 4
);

  logic                       mem_valid;
  logic [REG_W-1:0]           mem_reg;
  logic [DATA_W-1:0]          mem_data;
  logic                       alu_valid;
  logic [REG_W-1:0]           alu_reg;
  logic [DATA_W-1:0]          alu_data;
  logic                       enq_ready;

  logic [REG_W-1:0]           dst_reg;
  logic                       write_reg;
  logic [DATA_W-1:0]          dst_data;

  logic [REG_W-1:0]           lk_reg1;
  logic [REG_W-1:0]           lk_reg2;
  logic                       lk_hit1;
  logic                       lk_hit2;
  logic [DATA_W-1:0]          lk_data1;
  logic [DATA_W-1:0]          lk_data2;

  logic [$clog2(DEPTH+1)-1:0] count;

  modport master (
    output mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data, lk_reg1, lk_reg2,
    input  enq_ready, dst_reg, write_reg, dst_data, lk_hit1, lk_hit2, lk_data1, lk_data2, count
  );

  modport slave (
    input  mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data, lk_reg1, lk_reg2,
    output enq_ready, dst_reg, write_reg, dst_data, lk_hit1, lk_hit2, lk_data1, lk_data2, count
  );

endinterface

// File: rtl/writeback_queue_youngest_match.sv
// wbq_youngest_match: searches the occupied queue entries for a register and returns
// the data of the youngest match (closest to tail).
module wbq_youngest_match
  import wisc_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  wb_entry_t [DEPTH-1:0] entries,
  input  logic [PW-1:0]         head,
  input  logic [CW-1:0]         count,
  input  logic [REG_W-1:0]      lk_reg,
  output logic                  hit,
  output logic [DATA_W-1:0]     data
);

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (entries[head + PW'(i)].rd == lk_reg)) begin
        hit  = 1'b1;
        data = entries[head + PW'(i)].data;
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// In-order write-back queue feeding the register-file write port, with two-producer enqueue
// and operand forwarding. Build option WRITEBACK_QUEUE_DROP_R0_EN discards writes to R0.
module writeback_queue
  import wisc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  writeback_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  wb_entry_t [DEPTH-1:0] entries;
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         cnt;

  logic                  mem_acc;
  logic                  alu_acc;
  logic                  mem_st;
  logic                  alu_st;
  logic                  deq;
  logic                  hit1;
  logic                  hit2;
  logic [DATA_W-1:0]     data1;
  logic [DATA_W-1:0]     data2;

  assign bus.enq_ready = rst && (cnt <= CW'(DEPTH-2));
  assign mem_acc       = bus.enq_ready && bus.mem_valid;
  assign alu_acc       = bus.enq_ready && bus.alu_valid;

`ifdef WRITEBACK_QUEUE_DROP_R0_EN
  // R0 requests complete the handshake but never occupy a slot.
  assign mem_st = mem_acc && (bus.mem_reg != R0_IDX);
  assign alu_st = alu_acc && (bus.alu_reg != R0_IDX);
`else
  assign mem_st = mem_acc;
  assign alu_st = alu_acc;
`endif

  assign deq = rst && (cnt != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      tail <= tail + PW'(mem_st) + PW'(alu_st);
      if (deq) head <= head + PW'(1);
      cnt  <= cnt + CW'(mem_st) + CW'(alu_st) - CW'(deq);
    end
  end

  // Storage is not reset; only slots between head and tail are ever observed.
  always_ff @(posedge clk) begin
    if (mem_st) entries[tail] <= wb_entry_t'{rd: bus.mem_reg, data: bus.mem_data};
    if (alu_st) entries[tail + PW'(mem_st)] <= wb_entry_t'{rd: bus.alu_reg, data: bus.alu_data};
  end

  assign bus.write_reg = deq;
  assign bus.dst_reg   = deq ? entries[head].rd   : '0;
  assign bus.dst_data  = deq ? entries[head].data : '0;
  assign bus.count     = rst ? cnt : '0;

  wbq_youngest_match #(.DEPTH(DEPTH)) u_match1 (
    .entries (entries),
    .head    (head),
    .count   (cnt),
    .lk_reg  (bus.lk_reg1),
    .hit     (hit1),
    .data    (data1)
  );

  wbq_youngest_match #(.DEPTH(DEPTH)) u_match2 (
    .entries (entries),
    .head    (head),
    .count   (cnt),
    .lk_reg  (bus.lk_reg2),
    .hit     (hit2),
    .data    (data2)
  );

  assign bus.lk_hit1  = rst && hit1;
  assign bus.lk_hit2  = rst && hit2;
  assign bus.lk_data1 = (rst && hit1) ? data1 : '0;
  assign bus.lk_data2 = (rst && hit2) ? data2 : '0;

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: the driver queues expected retirements, a negedge
// monitor checks every register-file write, lookup, count and enq_ready against them.
module tb_writeback_queue;
  import wisc_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  writeback_queue_if #(.DEPTH(DEPTH)) bus ();

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wb_entry_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit stored(input logic [REG_W-1:0] r);
`ifdef WRITEBACK_QUEUE_DROP_R0_EN
    return r != R0_IDX;
`else
    return 1'b1;
`endif
  endfunction

  // Drive one cycle of stimulus; after the edge, record what the queue should now hold.
  task automatic step(input logic r,
                      input logic mv, input logic [REG_W-1:0] mr, input logic [DATA_W-1:0] md,
                      input logic av, input logic [REG_W-1:0] ar, input logic [DATA_W-1:0] ad);
    bit        ready;
    wb_entry_t pend[$];
    rst           = r;
    bus.mem_valid = mv;
    bus.mem_reg   = mr;
    bus.mem_data  = md;
    bus.alu_valid = av;
    bus.alu_reg   = ar;
    bus.alu_data  = ad;
    ready = r && (sb.size() <= DEPTH-2);
    if (ready && mv && stored(mr)) pend.push_back(wb_entry_t'{rd: mr, data: md});
    if (ready && av && stored(ar)) pend.push_back(wb_entry_t'{rd: ar, data: ad});
    @(posedge clk);
    #1;
    if (!r) sb.delete();
    else foreach (pend[k]) sb.push_back(pend[k]);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(rst, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  always @(negedge clk) begin
    logic              eh1;
    logic              eh2;
    logic [DATA_W-1:0] ed1;
    logic [DATA_W-1:0] ed2;
    wb_entry_t         e;
    eh1 = 1'b0; eh2 = 1'b0; ed1 = '0; ed2 = '0;
    if (rst) begin
      for (int i = 0; i < sb.size(); i++) begin
        if (sb[i].rd == bus.lk_reg1) begin eh1 = 1'b1; ed1 = sb[i].data; end
        if (sb[i].rd == bus.lk_reg2) begin eh2 = 1'b1; ed2 = sb[i].data; end
      end
    end
    check("enq_ready", 32'(bus.enq_ready), 32'(rst && (sb.size() <= DEPTH-2)));
    check("count", 32'(bus.count), rst ? 32'(sb.size()) : 32'd0);
    check("lk_hit1", 32'(bus.lk_hit1), 32'(eh1));
    check("lk_data1", 32'(bus.lk_data1), 32'(ed1));
    check("lk_hit2", 32'(bus.lk_hit2), 32'(eh2));
    check("lk_data2", 32'(bus.lk_data2), 32'(ed2));
    check("write_reg", 32'(bus.write_reg), 32'(rst && (sb.size() > 0)));
    if (bus.write_reg && sb.size() > 0) begin
      e = sb.pop_front();
      check("dst_reg", 32'(bus.dst_reg), 32'(e.rd));
      check("dst_data", 32'(bus.dst_data), 32'(e.data));
    end else if (!bus.write_reg) begin
      check("dst_reg_idle", 32'(bus.dst_reg), 32'd0);
      check("dst_data_idle", 32'(bus.dst_data), 32'd0);
    end
  end

  initial begin
    bus.mem_valid = 1'b0; bus.mem_reg = '0; bus.mem_data = '0;
    bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
    bus.lk_reg1   = 4'd3; bus.lk_reg2 = 4'd5;

    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    check("idle_enq_ready", 32'(bus.enq_ready), 32'd1);
    check("idle_count", 32'(bus.count), 32'd0);
    check("idle_write_reg", 32'(bus.write_reg), 32'd0);

    // Dual enqueue: mem is older and retires first.
    step(1'b1, 1'b1, 4'd3, 16'h1111, 1'b1, 4'd5, 16'h2222);
    check("dual_first_we", 32'(bus.write_reg), 32'd1);
    check("dual_first_reg", 32'(bus.dst_reg), 32'd3);
    check("dual_first_data", 32'(bus.dst_data), 32'h1111);
    check("dual_count", 32'(bus.count), 32'd2);
    idle(1);
    check("dual_second_reg", 32'(bus.dst_reg), 32'd5);
    check("dual_second_data", 32'(bus.dst_data), 32'h2222);
    idle(2);

    // Sustained dual enqueue: enq_ready drops at count 3, requests while low are lost.
    bus.lk_reg1 = 4'd2;
    bus.lk_reg2 = 4'd8;
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b1, 4'(i + 1), 16'h1000 + 16'(i), 1'b1, 4'(i + 8), 16'h2000 + 16'(i));
    for (int k = 0; k < 10 && sb.size() > 0; k++) idle(1);

    // Two writes to R7: lookup must return the younger value.
    bus.lk_reg1 = 4'd7;
    bus.lk_reg2 = 4'd3;
    step(1'b1, 1'b1, 4'd7, 16'h00AA, 1'b1, 4'd7, 16'h00BB);
    check("r7_hit", 32'(bus.lk_hit1), 32'd1);
    check("r7_data", 32'(bus.lk_data1), 32'h00BB);
    idle(1);
    check("r7_hit_tail", 32'(bus.lk_hit1), 32'd1);
    check("r7_data_tail", 32'(bus.lk_data1), 32'h00BB);
    idle(2);
    check("r7_hit_gone", 32'(bus.lk_hit1), 32'd0);

    // Three entries queued, then reset discards them.
    bus.lk_reg1 = 4'd4;
    step(1'b1, 1'b1, 4'd1, 16'h0101, 1'b1, 4'd2, 16'h0202);
    step(1'b1, 1'b1, 4'd4, 16'h0404, 1'b1, 4'd6, 16'h0606);
    check("pre_reset_count", 32'(bus.count), 32'd3);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    check("post_reset_count", 32'(bus.count), 32'd0);
    check("post_reset_we", 32'(bus.write_reg), 32'd0);
    idle(2);

    // Write to R0.
    bus.lk_reg1 = 4'd0;
    step(1'b1, 1'b0, '0, '0, 1'b1, 4'd0, 16'hFFFF);
`ifdef WRITEBACK_QUEUE_DROP_R0_EN
    check("r0_count", 32'(bus.count), 32'd0);
    check("r0_we", 32'(bus.write_reg), 32'd0);
    check("r0_hit", 32'(bus.lk_hit1), 32'd0);
`else
    check("r0_we", 32'(bus.write_reg), 32'd1);
    check("r0_reg", 32'(bus.dst_reg), 32'd0);
    check("r0_data", 32'(bus.dst_data), 32'hFFFF);
`endif
    for (int k = 0; k < 20 && sb.size() > 0; k++) idle(1);
    check("drain_empty", 32'(sb.size()), 32'd0);
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
